imm_decode_stage: RTL and testbench

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

---
 rtl/imm_pkg.sv | 29 ++
 rtl/imm_extract.sv | 48 ++++
 rtl/imm_decode_stage.sv | 100 ++++++++++
 tb/tb_imm_decode_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared opcode constants, format codes and legal datapath widths
package imm_pkg;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } imm_fmt_e;

endpackage

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational instruction format classifier and immediate extractor
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  // Classify by full 7-bit opcode; any word whose low bits are not 2'b11 misses every entry.
  always_comb begin
    fmt = FMT_ILL;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: fmt = FMT_I;
      OPC_STORE:                      fmt = FMT_S;
      OPC_BRANCH:                     fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
      OPC_JAL:                        fmt = FMT_J;
      OPC_OP:                         fmt = FMT_R;
      OPC_OP_IMM_32: begin
        if (XLEN == XLEN_64) fmt = FMT_I;
      end
      OPC_OP_32: begin
        if (XLEN == XLEN_64) fmt = FMT_R;
      end
      default:                        fmt = FMT_ILL;
    endcase
  end

  // Reassemble the immediate for the decoded format and sign-extend it to XLEN.
  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = XLEN'($signed(instr[31:20]));
      FMT_S:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FMT_B:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FMT_J:   imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      FMT_U:   imm = XLEN'($signed({instr[31:12], 12'b0}));
      default: imm = '0;
    endcase
  end

  assign illegal = (fmt == FMT_ILL);

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - two-entry decode buffer holding immediate, format and branch target
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit TARGET_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target
);

  localparam int DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  logic [1:0]      count_q, count_d;
  logic            in_ready_q, in_ready_d;
  entry_t          slot_q [DEPTH];
  entry_t          slot_d [DEPTH];

  logic [XLEN-1:0] new_imm;
  imm_fmt_e        new_fmt;
  logic            new_illegal;
  entry_t          new_entry;
  logic            push_wr;
  logic            pop;
  logic [1:0]      after_pop;
  logic            wr_idx;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (in_instr),
    .imm     (new_imm),
    .fmt     (new_fmt),
    .illegal (new_illegal)
  );

  // Build the entry at push time so the target adder sits before the buffer, not after it.
  always_comb begin
    new_entry         = '0;
    new_entry.imm     = new_imm;
    new_entry.pc      = in_pc;
    new_entry.target  = TARGET_EN ? (in_pc + new_imm) : '0;
    new_entry.fmt     = new_fmt;
    new_entry.illegal = new_illegal;
  end

  // Slot 0 is always the head; a pop shifts slot 1 down, and an emptying pop leaves slot 0 as-is.
  always_comb begin
    push_wr   = in_valid & in_ready_q & ~flush;
    pop       = (count_q != 2'd0) & out_ready;
    after_pop = count_q - {1'b0, pop};
    wr_idx    = after_pop[0];
    slot_d    = slot_q;
    if (pop && (count_q == 2'd2)) slot_d[0] = slot_q[1];
    if (push_wr) slot_d[wr_idx] = new_entry;
    if (flush) count_d = 2'd0;
    else       count_d = after_pop + {1'b0, push_wr};
    in_ready_d = (count_d != 2'd2);
  end

  // State update; reset clears occupancy and entry contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      in_ready_q <= 1'b1;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (count_q != 2'd0);
  assign out_imm     = slot_q[0].imm;
  assign out_fmt     = slot_q[0].fmt;
  assign out_illegal = slot_q[0].illegal;
  assign out_pc      = slot_q[0].pc;
  assign out_target  = slot_q[0].target;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - randomized and directed bench for imm_decode_stage at XLEN 32 and 64
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        r32, v32, ill32;
  logic [31:0] imm32, pc32, tgt32;
  logic [2:0]  fmt32;
  logic        r64, v64, ill64;
  logic [63:0] imm64, pc64, tgt64;
  logic [2:0]  fmt64;

  int total = 0;
  int bad   = 0;

  logic [31:0] q_instr [$];
  logic [63:0] q_pc    [$];

  logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                           7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F};

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TARGET_EN(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
    .out_valid(v32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32),
    .out_illegal(ill32), .out_pc(pc32), .out_target(tgt32)
  );

  imm_decode_stage #(.XLEN(64), .TARGET_EN(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(v64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64),
    .out_illegal(ill64), .out_pc(pc64), .out_target(tgt64)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode written from the field-placement rules with integer arithmetic.
  function automatic void ref_dec(input int xlen, input logic [31:0] w,
                                  output logic [63:0] imm, output logic [2:0] fmt);
    longint uw = w;
    longint v  = 0;
    int     op = int'(w & 32'h7F);
    fmt = 3'd7;
    case (op)
      'h03, 'h13, 'h67: fmt = 3'd1;
      'h1B: if (xlen == 64) fmt = 3'd1;
      'h23: fmt = 3'd2;
      'h63: fmt = 3'd3;
      'h37, 'h17: fmt = 3'd4;
      'h6F: fmt = 3'd5;
      'h33: fmt = 3'd0;
      'h3B: if (xlen == 64) fmt = 3'd0;
      default: fmt = 3'd7;
    endcase
    case (fmt)
      3'd1: begin v = uw >> 20; if (v >= 2048) v -= 4096; end
      3'd2: begin
        v = ((uw >> 25) * 32) + ((uw >> 7) & 31);
        if (v >= 2048) v -= 4096;
      end
      3'd3: begin
        v = ((uw >> 31) & 1) * 4096 + ((uw >> 7) & 1) * 2048
          + ((uw >> 25) & 63) * 32 + ((uw >> 8) & 15) * 2;
        if (v >= 4096) v -= 8192;
      end
      3'd5: begin
        v = ((uw >> 31) & 1) * 1048576 + ((uw >> 12) & 255) * 4096
          + ((uw >> 20) & 1) * 2048 + ((uw >> 21) & 1023) * 2;
        if (v >= 1048576) v -= 2097152;
      end
      3'd4: begin
        v = uw & 64'hFFFFF000;
        if (v >= 64'h80000000) v -= 64'h100000000;
      end
      default: v = 0;
    endcase
    imm = (xlen == 32) ? (v & 64'hFFFFFFFF) : v;
  endfunction

  task automatic check_state();
    logic [63:0] e_imm, e_pc, m;
    logic [2:0]  e_fmt;
    int n = q_instr.size();
    chk("valid32", {63'b0, v32}, {63'b0, (n > 0)});
    chk("ready32", {63'b0, r32}, {63'b0, (n < 2)});
    chk("valid64", {63'b0, v64}, {63'b0, (n > 0)});
    chk("ready64", {63'b0, r64}, {63'b0, (n < 2)});
    if (n > 0) begin
      m = 64'hFFFFFFFF;
      ref_dec(32, q_instr[0], e_imm, e_fmt);
      e_pc = q_pc[0] & m;
      chk("imm32", {32'b0, imm32}, e_imm);
      chk("fmt32", {61'b0, fmt32}, {61'b0, e_fmt});
      chk("ill32", {63'b0, ill32}, {63'b0, (e_fmt == 3'd7)});
      chk("pc32", {32'b0, pc32}, e_pc);
      chk("tgt32", {32'b0, tgt32}, (e_pc + e_imm) & m);
      ref_dec(64, q_instr[0], e_imm, e_fmt);
      e_pc = q_pc[0];
      chk("imm64", imm64, e_imm);
      chk("fmt64", {61'b0, fmt64}, {61'b0, e_fmt});
      chk("ill64", {63'b0, ill64}, {63'b0, (e_fmt == 3'd7)});
      chk("pc64", pc64, e_pc);
      chk("tgt64", tgt64, e_pc + e_imm);
    end
  endtask

  task automatic cyc(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                     input bit ordy, input bit fl, input bit rn);
    int n;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rn;
    @(posedge clk);
    n = q_instr.size();
    if (!rn) begin
      q_instr.delete();
      q_pc.delete();
    end else begin
      if (n > 0 && ordy) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (fl) begin
        q_instr.delete();
        q_pc.delete();
      end else if (v && n < 2) begin
        q_instr.push_back(ins);
        q_pc.push_back(pc);
      end
    end
    @(negedge clk);
    check_state();
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] ins;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_imm32", {32'b0, imm32}, 64'd0);
    chk("rst_tgt64", tgt64, 64'd0);

    cyc(1, 32'hFFF00093, 64'h0, 0, 0, 1);
    chk("addi_imm32", {32'b0, imm32}, 64'hFFFFFFFF);
    chk("addi_fmt32", {61'b0, fmt32}, 64'd1);
    cyc(0, 0, 0, 1, 0, 1);

    cyc(1, 32'hFE000EE3, 64'h100, 0, 0, 1);
    chk("beq_imm32", {32'b0, imm32}, 64'hFFFFFFFC);
    chk("beq_fmt32", {61'b0, fmt32}, 64'd3);
    chk("beq_tgt32", {32'b0, tgt32}, 64'hFC);
    cyc(0, 0, 0, 1, 0, 1);

    cyc(1, 32'h0080006F, 64'h200, 0, 0, 1);
    cyc(1, 32'h0100006F, 64'h204, 0, 0, 1);
    chk("jal_full_ready", {63'b0, r32}, 64'd0);
    cyc(1, 32'h0180006F, 64'h208, 0, 0, 1);
    chk("jal_head_pc", {32'b0, pc32}, 64'h200);
    cyc(0, 0, 0, 1, 0, 1);
    chk("jal_second_pc", {32'b0, pc32}, 64'h204);
    cyc(0, 0, 0, 1, 0, 1);
    chk("jal_drained", {63'b0, v32}, 64'd0);

    cyc(1, 32'h800000B7, 64'h0, 0, 0, 1);
    chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
    chk("lui_fmt64", {61'b0, fmt64}, 64'd4);
    cyc(1, 32'h0000001B, 64'h0, 1, 0, 1);
    chk("w_fmt64", {61'b0, fmt64}, 64'd1);
    chk("w_ill32", {63'b0, ill32}, 64'd1);
    cyc(1, 32'h00000000, 64'h40, 1, 0, 1);
    chk("zero_ill64", {63'b0, ill64}, 64'd1);
    chk("zero_fmt64", {61'b0, fmt64}, 64'd7);
    chk("zero_imm64", imm64, 64'd0);
    cyc(0, 0, 0, 1, 0, 1);

    cyc(1, 32'h00500093, 64'h10, 0, 0, 1);
    cyc(1, 32'h00600093, 64'h14, 0, 0, 1);
    cyc(1, 32'h00700093, 64'h18, 0, 1, 1);
    chk("flush_valid", {63'b0, v64}, 64'd0);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 32'h00500093, 64'h10, 0, 0, 1);
    cyc(1, 32'h00600093, 64'h14, 0, 0, 1);
    cyc(1, 32'h00700093, 64'h18, 0, 0, 0);
    chk("reset_ready", {63'b0, r64}, 64'd1);
    cyc(0, 0, 0, 1, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom();
      if ($urandom_range(0, 7) == 0) ins = r;
      else ins = {r[31:7], ops[$urandom_range(0, 10)]};
      cyc($urandom_range(0, 3) != 0, ins, {$urandom(), $urandom()},
          $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0,
          $urandom_range(0, 63) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
